// File: rtl/pll_lock_sequencer.sv
// Audio PLL lock sequencer: holds the PLL in reset, waits for and qualifies lock,
// then releases the audio-domain reset; retries on timeout and parks in FAULT.
module pll_lock_sequencer #(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_relock,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       audio_rst,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        READY     = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic             lock_p0;
    logic             lock_s;
    logic [3:0]       retry_nxt;
    logic             lost_nxt;
    logic             restart;

    // Next-state decision; sw_relock overrides every lock event and expiry.
    always_comb begin
        nxt_state = cur_state;
        retry_nxt = retry_count;
        lost_nxt  = 1'b0;
        restart   = 1'b0;
        if (sw_relock) begin
            nxt_state = RESET_PLL;
            retry_nxt = 4'd0;
            restart   = 1'b1;
        end else begin
            case (cur_state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) nxt_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt_state = STABILIZE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            nxt_state = FAULT;
                        end else begin
                            retry_nxt = retry_count + 4'd1;
                            nxt_state = RESET_PLL;
                        end
                    end
                end
                STABILIZE: begin
                    if (!lock_s) nxt_state = WAIT_LOCK;
                    else if (cnt == STABLE_LAST) nxt_state = READY;
                end
                READY: begin
                    if (!lock_s) begin
                        nxt_state = RESET_PLL;
                        lost_nxt  = 1'b1;
                        retry_nxt = 4'd0;
                    end
                end
                FAULT:   nxt_state = FAULT;
                default: nxt_state = RESET_PLL;
            endcase
        end
    end

    // Stage p0 -> s: lock synchronizer; state, counter and outputs decoded from next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_p0     <= 1'b0;
            lock_s      <= 1'b0;
            cur_state   <= RESET_PLL;
            cnt         <= '0;
            retry_count <= 4'd0;
            pll_rst     <= 1'b1;
            clk_ready   <= 1'b0;
            audio_rst   <= 1'b1;
            lock_lost   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            lock_p0     <= pll_locked;
            lock_s      <= lock_p0;
            cur_state   <= nxt_state;
            cnt         <= (restart || (nxt_state != cur_state)) ? '0 : cnt + CNT_W'(1);
            retry_count <= retry_nxt;
            pll_rst     <= (nxt_state == RESET_PLL) || (nxt_state == FAULT);
            clk_ready   <= (nxt_state == READY);
            audio_rst   <= (nxt_state != READY);
            lock_lost   <= lost_nxt;
            fault       <= (nxt_state == FAULT);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up/loss/fault/recovery scenarios plus
// randomized lock/relock/reset traffic, all checked against a dwell-time model.
module tb_pll_lock_sequencer;

    localparam int RST_C  = 4;
    localparam int STAB_C = 8;
    localparam int TO_C   = 32;
    localparam int MAXR   = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_relock = 1'b0;
    logic       pll_rst, clk_ready, audio_rst, lock_lost, fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase (0..4 as in the encoded state), cycles spent in phase,
    // retries used, last lock_lost, and the two-deep lock delay line.
    int m_ph = 0;
    int m_dwell = 0;
    int m_tries = 0;
    int m_lost = 0;
    bit m_sq [2];

    pll_lock_sequencer #(
        .RST_CYCLES(RST_C),
        .LOCK_STABLE_CYCLES(STAB_C),
        .LOCK_TIMEOUT_CYCLES(TO_C),
        .MAX_RETRIES(MAXR)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .sw_relock(sw_relock),
        .pll_rst(pll_rst),
        .clk_ready(clk_ready),
        .audio_rst(audio_rst),
        .lock_lost(lock_lost),
        .fault(fault),
        .retry_count(retry_count),
        .state(state)
    );

    always #5 refclk = ~refclk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit sw, input bit raw);
        int  nph;
        bit  ls;
        if (r) begin
            m_ph = 0; m_dwell = 0; m_tries = 0; m_lost = 0;
            m_sq[0] = 1'b0; m_sq[1] = 1'b0;
        end else begin
            ls = m_sq[1];
            nph = m_ph;
            m_lost = 0;
            if (sw) begin
                nph = 0;
                m_tries = 0;
            end else begin
                case (m_ph)
                    0: if (m_dwell + 1 >= RST_C) nph = 1;
                    1: begin
                        if (ls) nph = 2;
                        else if (m_dwell + 1 >= TO_C) begin
                            if (m_tries >= MAXR) nph = 4;
                            else begin
                                m_tries++;
                                nph = 0;
                            end
                        end
                    end
                    2: begin
                        if (!ls) nph = 1;
                        else if (m_dwell + 1 >= STAB_C) nph = 3;
                    end
                    3: if (!ls) begin
                        nph = 0;
                        m_lost = 1;
                        m_tries = 0;
                    end
                    default: nph = m_ph;
                endcase
            end
            m_dwell = (sw || nph != m_ph) ? 0 : m_dwell + 1;
            m_ph = nph;
            m_sq[1] = m_sq[0];
            m_sq[0] = raw;
        end
    endtask

    task automatic compare_all();
        chk_eq("state", 32'(state), 32'(m_ph));
        chk_eq("pll_rst", 32'(pll_rst), 32'((m_ph == 0 || m_ph == 4) ? 1 : 0));
        chk_eq("clk_ready", 32'(clk_ready), 32'((m_ph == 3) ? 1 : 0));
        chk_eq("audio_rst", 32'(audio_rst), 32'((m_ph == 3) ? 0 : 1));
        chk_eq("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk_eq("fault", 32'(fault), 32'((m_ph == 4) ? 1 : 0));
        chk_eq("retry_count", 32'(retry_count), 32'(m_tries));
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge(rst, sw_relock, pll_locked);
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int run;

        // Reset state
        repeat (3) step();
        rst = 1'b0;

        // Clean bring-up: pll_rst width, then lock raised 10 cycles after release
        n = 0;
        while (pll_rst && n < 20) begin step(); n++; end
        chk_eq("pll_rst_len", n, RST_C);
        repeat (10 - n) step();
        pll_locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 50) begin step(); n++; end
        chk_eq("bringup_latency", n, 11);
        chk_eq("bringup_retry", 32'(retry_count), 0);

        // Loss of lock in READY
        repeat (5) step();
        pll_locked = 1'b0;
        n = 0;
        while (!lock_lost && n < 10) begin step(); n++; end
        chk_eq("lost_latency", n, 3);
        chk_eq("lost_state", 32'(state), 0);
        step();
        chk_eq("lost_single_pulse", 32'(lock_lost), 0);
        pll_locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 100) begin step(); n++; end
        chk_eq("relock_ready", 32'(clk_ready), 1);
        chk_eq("relock_retry", 32'(retry_count), 0);

        // Glitchy lock: 3-cycle pulse, then steady lock
        pll_locked = 1'b0;
        sw_relock = 1'b1;
        step();
        sw_relock = 1'b0;
        repeat (6) step();
        pll_locked = 1'b1;
        repeat (3) step();
        pll_locked = 1'b0;
        repeat (5) step();
        chk_eq("glitch_state", 32'(state), 1);
        chk_eq("glitch_retry", 32'(retry_count), 0);
        pll_locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 50) begin step(); n++; end
        chk_eq("glitch_latency", n, 11);

        // Timeouts to FAULT with lock held low
        pll_locked = 1'b0;
        sw_relock = 1'b1;
        n = 0;
        while (!fault && n < 400) begin
            step();
            sw_relock = 1'b0;
            n++;
        end
        chk_eq("fault_latency", n, 1 + (MAXR + 1) * (RST_C + TO_C));
        chk_eq("fault_retry", 32'(retry_count), MAXR);
        repeat (20) step();
        chk_eq("fault_pll_rst", 32'(pll_rst), 1);
        chk_eq("fault_held", 32'(fault), 1);

        // Recovery from FAULT
        sw_relock = 1'b1;
        step();
        sw_relock = 1'b0;
        chk_eq("recover_fault", 32'(fault), 0);
        chk_eq("recover_retry", 32'(retry_count), 0);
        chk_eq("recover_state", 32'(state), 0);

        // sw_relock coinciding with STABILIZE expiry
        pll_locked = 1'b1;
        n = 0;
        while (state != 3'd2 && n < 60) begin step(); n++; end
        chk_eq("reach_stab", 32'(state), 2);
        repeat (STAB_C - 1) step();
        sw_relock = 1'b1;
        step();
        sw_relock = 1'b0;
        chk_eq("relock_beats_ready", 32'(state), 0);
        chk_eq("relock_no_ready", 32'(clk_ready), 0);

        // Mid-operation reset in STABILIZE with lock toggling during reset
        n = 0;
        while (state != 3'd2 && n < 60) begin step(); n++; end
        step();
        rst = 1'b1;
        step();
        chk_eq("midrst_state", 32'(state), 0);
        chk_eq("midrst_audio_rst", 32'(audio_rst), 1);
        repeat (4) begin
            pll_locked = ~pll_locked;
            step();
        end
        pll_locked = 1'b0;
        rst = 1'b0;
        repeat (RST_C + 4) step();
        chk_eq("midrst_wait", 32'(state), 1);

        // Randomized traffic
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                pll_locked = 1'($urandom_range(0, 1));
                run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 60));
            end
            run--;
            sw_relock = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        sw_relock = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the audio-clock PLL (50 MHz reference in, 11.2896 MHz out) through reset, lock acquisition and lock qualification. It releases a clean reset to the audio clock domain only after lock has been stable for a programmable interval. It detects loss of lock and re-initialises the PLL automatically, with bounded retries and a sticky fault. It sits beside the PLL instance in the `soc_system` top level and runs on the 50 MHz reference clock.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before ready (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK before a retry (≥2).
- `MAX_RETRIES`, 3: retries after the first attempt before FAULT (0–15).

Ports:
- `refclk`  in  1  50 MHz reference clock; sole clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  raw PLL lock, asynchronous to `refclk`.
- `sw_relock`  in  1  single-cycle request to restart the sequence.
- `pll_rst`  out  1  reset to the PLL.
- `clk_ready`  out  1  high while the PLL is qualified-locked.
- `audio_rst`  out  1  active-high reset for audio-domain logic; equals `~clk_ready`.
- `lock_lost`  out  1  one-cycle pulse on loss of lock from READY.
- `fault`  out  1  high in FAULT.
- `retry_count`  out  4  retries used in the current sequence.
- `state`  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, READY=3, FAULT=4.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to `lock_s`. All decisions use `lock_s`.
- One counter, sized `$clog2` of the largest count parameter, is cleared on every state entry.
- Priority: `rst` > `sw_relock` > lock events > counter expiry.
- RESET_PLL: `pll_rst`=1. Leave for WAIT_LOCK when counter == RST_CYCLES-1.
- WAIT_LOCK: `pll_rst`=0.
  - `lock_s`=1 → STABILIZE.
  - Counter == LOCK_TIMEOUT_CYCLES-1 with no lock:
    - if `retry_count` == MAX_RETRIES → FAULT;
    - else `retry_count`+1 → RESET_PLL.
- STABILIZE: `lock_s`=0 → WAIT_LOCK. This is not a retry; the timeout restarts. Counter == LOCK_STABLE_CYCLES-1 with `lock_s`=1 → READY.
- READY: `clk_ready`=1, `audio_rst`=0. `lock_s`=0 → RESET_PLL; `lock_lost` pulses; `retry_count` clears.
- FAULT: `fault`=1. `pll_rst`=1 is held so the PLL stays parked. Remains here until `sw_relock` or `rst`.
- `sw_relock` in any state → RESET_PLL with `retry_count`=0 and `fault` cleared. In RESET_PLL it restarts the reset count.
- All outputs are registered and decoded from next state, so they take their new value on the same edge the state changes.

## Timing
- During and after `rst`: state=RESET_PLL, `pll_rst`=1, `clk_ready`=0, `audio_rst`=1, `lock_lost`=0, `fault`=0, `retry_count`=0, counter=0, synchronizer=0.
- `pll_rst` is high for exactly RST_CYCLES cycles after `rst` deasserts, and for RST_CYCLES cycles per retry.
- `pll_locked` rising edge to `lock_s`: 2 cycles.
- `lock_s` first high in WAIT_LOCK at cycle N:
  - STABILIZE at N+1;
  - `clk_ready` rises at N+1+LOCK_STABLE_CYCLES if lock is held throughout.
- Raw lock drop in READY: `clk_ready` falls, and `audio_rst`, `lock_lost` and `pll_rst` rise, 3 cycles after the raw drop (2 synchronizer + 1).
- Timeout: RESET_PLL is re-entered LOCK_TIMEOUT_CYCLES cycles after WAIT_LOCK entry.
- Total attempts before FAULT = MAX_RETRIES+1.
- A `sw_relock` that coincides with a lock event or a counter expiry wins.

## Test plan
Common parameters: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up: release `rst`, raise `pll_locked` 10 cycles later and hold it → `pll_rst` high 4 cycles; `clk_ready`=1 and `audio_rst`=0 exactly 11 cycles after raw lock rises; `retry_count`=0.
- Glitchy lock: 3-cycle lock pulse, then steady lock → STABILIZE→WAIT_LOCK with no retry increment; READY 11 cycles after the steady lock edge.
- Timeouts to fault: `pll_locked` held 0 → three 32-cycle WAIT_LOCK windows separated by 4-cycle `pll_rst` pulses; `retry_count` 0→1→2; `fault`=1 and `pll_rst`=1 held thereafter.
- Loss of lock: drop `pll_locked` in READY → 3 cycles later a single `lock_lost` pulse, `clk_ready`=0, state=RESET_PLL; relock gives READY again with `retry_count`=0.
- Recovery: `sw_relock` in FAULT → `fault`=0, `retry_count`=0, RESET_PLL; `sw_relock` in the same cycle as counter expiry in STABILIZE → RESET_PLL, not READY.
- Mid-operation reset: assert `rst` in STABILIZE → next cycle all outputs at reset values; an async lock toggle during `rst` has no effect.
